// File: rtl/fracnet_mul_acc_pipe.sv
// Pipelined multiply-accumulate lane for FracNet conv engines: parametrised
// operand widths, optional signed mode, grouped accumulation with saturation.
module fracnet_mul_acc_pipe #(
  parameter int unsigned DIN0_WIDTH = 11,
  parameter int unsigned DIN1_WIDTH = 5,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic                             in_valid,
  input  logic [DIN0_WIDTH-1:0]            din0,
  input  logic [DIN1_WIDTH-1:0]            din1,
  input  logic                             first,
  input  logic                             last,
  output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod,
  output logic                             prod_valid,
  output logic [ACC_WIDTH-1:0]             dout,
  output logic                             out_valid,
  output logic                             ovf
);

  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;

  logic [PW-1:0]        a_ext_c;
  logic [PW-1:0]        b_ext_c;
  logic [PW-1:0]        mul_c;
  logic [PW-1:0]        pd [NUM_STAGE];
  logic [NUM_STAGE-1:0] pv;
  logic [NUM_STAGE-1:0] pf;
  logic [NUM_STAGE-1:0] pl;

  logic [ACC_WIDTH-1:0] acc;
  logic                 sticky;
  logic [ACC_WIDTH-1:0] ext_c;
  logic [ACC_WIDTH:0]   sum_c;
  logic [ACC_WIDTH-1:0] sat_c;
  logic                 add_ovf_c;
  logic [ACC_WIDTH-1:0] acc_nxt_c;
  logic                 sticky_nxt_c;

  // Operands are widened to the full product width first, so the low PW bits
  // of the PW x PW product are exact for both signed and unsigned operands.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext_c = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
      b_ext_c = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
    end else begin
      a_ext_c = {{DIN1_WIDTH{1'b0}}, din0};
      b_ext_c = {{DIN0_WIDTH{1'b0}}, din1};
    end
    mul_c = a_ext_c * b_ext_c;
  end

  // Product pipe; data registers only load on valid beats so the tail holds
  // the last real product through bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      pf <= '0;
      pl <= '0;
      for (int i = 0; i < NUM_STAGE; i++) pd[i] <= '0;
    end else if (ce) begin
      pv[0] <= in_valid;
      pf[0] <= in_valid & first;
      pl[0] <= in_valid & last;
      if (in_valid) pd[0] <= mul_c;
      for (int i = 1; i < NUM_STAGE; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pl[i] <= pl[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign prod       = pd[NUM_STAGE-1];
  assign prod_valid = pv[NUM_STAGE-1];

  // Extend the tail product, add with one guard bit and clamp on overflow.
  always_comb begin
    if (SIGNED != 0) ext_c = ACC_WIDTH'($signed(pd[NUM_STAGE-1]));
    else             ext_c = ACC_WIDTH'(pd[NUM_STAGE-1]);
    sum_c = {1'b0, acc} + {1'b0, ext_c};
    if (SIGNED != 0) begin
      add_ovf_c = (acc[ACC_WIDTH-1] == ext_c[ACC_WIDTH-1]) &&
                  (sum_c[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
      sat_c     = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      add_ovf_c = sum_c[ACC_WIDTH];
      sat_c     = '1;
    end
    if (pf[NUM_STAGE-1]) begin
      acc_nxt_c    = ext_c;
      sticky_nxt_c = 1'b0;
    end else begin
      acc_nxt_c    = add_ovf_c ? sat_c : sum_c[ACC_WIDTH-1:0];
      sticky_nxt_c = sticky | add_ovf_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      sticky    <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= pv[NUM_STAGE-1] & pl[NUM_STAGE-1];
      if (pv[NUM_STAGE-1]) begin
        acc    <= acc_nxt_c;
        sticky <= sticky_nxt_c;
        if (pl[NUM_STAGE-1]) begin
          dout <= acc_nxt_c;
          ovf  <= sticky_nxt_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fracnet_mul_acc_pipe.sv
// Bench for fracnet_mul_acc_pipe: unsigned and signed lanes driven in parallel,
// checked every cycle against a queue-based arithmetic model plus literal results.
module tb_fracnet_mul_acc_pipe;

  localparam int unsigned NS = 3;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, first, last;
  logic [10:0] din0;
  logic [4:0]  din1;

  logic [15:0] prod   [2];
  logic        pvld   [2];
  logic [19:0] dout   [2];
  logic        ovld   [2];
  logic        ovf    [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fracnet_mul_acc_pipe #(.SIGNED(0)) u_uns (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .prod(prod[0]), .prod_valid(pvld[0]), .dout(dout[0]),
    .out_valid(ovld[0]), .ovf(ovf[0]));

  fracnet_mul_acc_pipe #(.SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .prod(prod[1]), .prod_valid(pvld[1]), .dout(dout[1]),
    .out_valid(ovld[1]), .ovf(ovf[1]));

  typedef struct {
    logic        v, f, l;
    logic [10:0] a;
    logic [4:0]  b;
  } beat_t;

  // Model: queue of records, one per ce=1 edge, aged NS edges before folding.
  beat_t  hist[$];
  longint m_acc [2], m_prod [2], m_dout [2];
  bit     m_sticky [2], m_pv [2], m_ov [2], m_ovf [2];

  function automatic longint pval(int s, logic [10:0] a, logic [4:0] b);
    if (s != 0) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_prod[i] = 0; m_dout[i] = 0;
        m_sticky[i] = 0; m_pv[i] = 0; m_ov[i] = 0; m_ovf[i] = 0;
      end
    end else if (ce) begin
      beat_t nb;
      for (int i = 0; i < 2; i++) m_ov[i] = 0;
      if (hist.size() == NS) begin
        beat_t t;
        t = hist.pop_front();
        if (t.v) begin
          for (int i = 0; i < 2; i++) begin
            longint p, s, lo, hi;
            p  = pval(i, t.a, t.b);
            lo = (i != 0) ? -(longint'(1) << 19) : 0;
            hi = (i != 0) ? (longint'(1) << 19) - 1 : (longint'(1) << 20) - 1;
            if (t.f) begin
              m_acc[i] = p; m_sticky[i] = 0;
            end else begin
              s = m_acc[i] + p;
              if (s > hi) begin m_acc[i] = hi; m_sticky[i] = 1; end
              else if (s < lo) begin m_acc[i] = lo; m_sticky[i] = 1; end
              else m_acc[i] = s;
            end
            if (t.l) begin
              m_dout[i] = m_acc[i]; m_ovf[i] = m_sticky[i]; m_ov[i] = 1;
            end
          end
        end
      end
      nb.v = in_valid; nb.f = in_valid & first; nb.l = in_valid & last;
      nb.a = din0; nb.b = din1;
      hist.push_back(nb);
      for (int i = 0; i < 2; i++) begin
        m_pv[i] = 0;
        if (hist.size() == NS && hist[0].v) begin
          m_pv[i] = 1; m_prod[i] = pval(i, hist[0].a, hist[0].b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] ep;
        logic [19:0] ed;
        ep = 16'(m_prod[i]);
        ed = 20'(m_dout[i]);
        chk($sformatf("prod[%0d]", i), longint'(prod[i]), longint'(ep));
        chk($sformatf("prod_valid[%0d]", i), longint'(pvld[i]), longint'(m_pv[i]));
        chk($sformatf("dout[%0d]", i), longint'(dout[i]), longint'(ed));
        chk($sformatf("out_valid[%0d]", i), longint'(ovld[i]), longint'(m_ov[i]));
        chk($sformatf("ovf[%0d]", i), longint'(ovf[i]), longint'(m_ovf[i]));
      end
    end
  end

  task automatic drive(input logic c, input logic v, input logic [10:0] a,
                       input logic [4:0] b, input logic f, input logic l);
    ce = c; in_valid = v; din0 = a; din1 = b; first = f; last = l;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Wait (bounded) for the next out_valid pulse on lane i and pin its result.
  task automatic expect_result(input string name, input int i, input logic [19:0] ed,
                               input logic eo);
    bit seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (ovld[i]) seen = 1;
      else idle();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no out_valid within 20 cycles", name);
    end else begin
      chk({name, "_dout"}, longint'(dout[i]), longint'(ed));
      chk({name, "_ovf"}, longint'(ovf[i]), longint'(eo));
    end
  endtask

  initial begin
    reset = 1; ce = 0; in_valid = 0; din0 = '0; din1 = '0; first = 0; last = 0;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_prod", longint'(prod[0]), 0);
    chk("rst_dout", longint'(dout[0]), 0);
    chk("rst_ovld", longint'(ovld[1]), 0);
    reset = 0;
    chk_en = 1;

    // Basic three-beat group, product latency and result.
    drive(1, 1, 11'd2047, 5'd31, 1, 0);
    drive(1, 1, 11'd1, 5'd1, 0, 0);
    drive(1, 1, 11'd100, 5'd5, 0, 1);
    chk("lat_prod", longint'(prod[0]), 63457);
    chk("lat_pvld", longint'(pvld[0]), 1);
    chk("lat_ovld_early", longint'(ovld[0]), 0);
    idle(); idle();
    chk("lat_ovld_edge", longint'(ovld[0]), 0);
    idle();
    chk("lat_ovld", longint'(ovld[0]), 1);
    chk("t1_dout", longint'(dout[0]), 63958);
    chk("t1_ovf", longint'(ovf[0]), 0);

    // Seventeen max beats saturate, then a single-beat group clears ovf.
    for (int n = 1; n <= 17; n++) drive(1, 1, 11'd2047, 5'd31, n == 1, n == 17);
    expect_result("sat", 0, 20'd1048575, 1);
    drive(1, 1, 11'd3, 5'd4, 1, 1);
    expect_result("single", 0, 20'd12, 0);

    // Signed lane: negative operands.
    drive(1, 1, 11'h400, 5'h10, 1, 0);
    drive(1, 1, 11'd1023, 5'd15, 0, 1);
    expect_result("sgn1", 1, 20'd31729, 0);
    idle();
    drive(1, 1, 11'h400, 5'd15, 1, 1);
    expect_result("sgn2", 1, 20'hFC400, 0);

    // Stalls and bubbles mid-group.
    drive(1, 1, 11'd10, 5'd3, 1, 0);
    for (int n = 0; n < 4; n++) drive(0, 1, 11'd99, 5'd9, 1, 1);
    drive(1, 0, 11'd55, 5'd5, 1, 1);
    drive(1, 1, 11'd20, 5'd2, 0, 0);
    drive(1, 1, 11'd7, 5'd7, 0, 1);
    expect_result("stall", 0, 20'd119, 0);

    // Reset with beats in flight and ce low.
    drive(1, 1, 11'd9, 5'd9, 1, 0);
    drive(1, 1, 11'd1, 5'd1, 0, 1);
    reset = 1; ce = 0; in_valid = 0;
    @(posedge clk); #2;
    reset = 0;
    chk("rr_prod", longint'(prod[0]), 0);
    chk("rr_pvld", longint'(pvld[0]), 0);
    chk("rr_dout", longint'(dout[0]), 0);
    chk("rr_ovld", longint'(ovld[0]), 0);
    for (int n = 0; n < 6; n++) idle();
    drive(1, 1, 11'd2, 5'd3, 0, 1);
    expect_result("after_rst", 0, 20'd6, 0);

    // Back-to-back single-beat groups.
    drive(1, 1, 11'd5, 5'd5, 1, 1);
    drive(1, 1, 11'd6, 5'd6, 1, 1);
    expect_result("b2b_a", 0, 20'd25, 0);
    idle();
    chk("b2b_ovld", longint'(ovld[0]), 1);
    chk("b2b_dout", longint'(dout[0]), 36);
    for (int n = 0; n < 4; n++) idle();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
